// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
//   Shared types and constants for the SRAM stream controller.
//   state_t     : controller FSM states (IDLE, LOAD, READ, FIN)
//   BUF_DEPTH   : read-return buffer depth, which is also the read credit limit
//   SRAM_RD_LAT : cycles from registering sram_adr to capturing sram_d_out
// -----------------------------------------------------------------------------
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      READ = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam int BUF_DEPTH   = 4;
   localparam int SRAM_RD_LAT = 2;

endpackage

// File: rtl/sram_rd_fifo.sv
// -----------------------------------------------------------------------------
// sram_rd_fifo
//   Small synchronous FIFO that buffers words returned by the SRAM. Each entry
//   is W bits; the controller packs {last_flag, data} into it.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     push     : write din this cycle (caller guarantees not full)
//     pop      : drop the head entry this cycle (caller guarantees not empty)
//     din      : entry to write
//     dout     : current head entry
//     count    : number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sram_rd_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign dout = mem[rd_ptr];

   // NOTE: the storage is reset as well (only a handful of entries) so the
   // head reads as zero after reset and an aborted run leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         // A simultaneous push and pop leaves the count unchanged.
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sram_stream_ctrl
//   On start, writes WR_WORDS words from the input stream into SRAM addresses
//   0..WR_WORDS-1, then reads addresses 0..RD_WORDS-1 back out as an output
//   stream. Reads are issued against a credit limit so the return buffer can
//   always absorb every word still in flight, even under backpressure.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     start               : run request, only honoured in IDLE
//     busy, done          : run in progress / one-cycle completion pulse
//     in_valid/in_ready/in_data             : load stream
//     out_valid/out_ready/out_data/out_last : read-back stream
//     sram_nWE/sram_adr/sram_d_in           : SRAM write/address/data port
//     sram_d_out          : SRAM read data (one cycle after the address)
// -----------------------------------------------------------------------------
module sram_stream_ctrl
   import sram_pkg::*;
#(
   parameter int AW       = 6,
   parameter int DW       = 32,
   parameter int WR_WORDS = 24,
   parameter int RD_WORDS = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          sram_nWE,
   output logic [AW-1:0] sram_adr,
   output logic [DW-1:0] sram_d_in,
   input  logic [DW-1:0] sram_d_out
);

   if (AW < 1 || DW < 1) begin : g_bad_width
      $fatal(1, "sram_stream_ctrl: AW and DW must be at least 1");
   end
   if (WR_WORDS < 0 || WR_WORDS > (1 << AW)) begin : g_bad_wr_words
      $fatal(1, "sram_stream_ctrl: WR_WORDS must be in 0..2**AW");
   end
   if (RD_WORDS < 1 || RD_WORDS > (1 << AW)) begin : g_bad_rd_words
      $fatal(1, "sram_stream_ctrl: RD_WORDS must be in 1..2**AW");
   end

   // Counters carry one extra bit so a full 2**AW count stays distinct from 0.
   localparam int          CW      = AW + 1;
   localparam int          FCW     = $clog2(BUF_DEPTH + 1);
   localparam logic [AW:0] WR_LAST = CW'((WR_WORDS == 0) ? 0 : WR_WORDS - 1);
   localparam logic [AW:0] RD_LAST = CW'(RD_WORDS - 1);
   localparam logic [AW:0] RD_END  = CW'(RD_WORDS);

   state_t                 state;
   state_t                 state_nx;
   logic [AW:0]            wr_cnt;
   logic [AW:0]            rd_cnt;
   logic                   beat;
   logic                   rd_issue;
   logic                   push;
   logic                   pop;
   logic [SRAM_RD_LAT-1:0] pipe_vld;   // reads in flight, oldest in the MSB
   logic [SRAM_RD_LAT-1:0] pipe_last;  // matching last-word tags
   logic [FCW-1:0]         fifo_count;
   logic [DW:0]            fifo_dout;

   assign beat = (state == LOAD) && in_valid;

   // Credit: buffered words plus words still in the SRAM pipeline must never
   // exceed the buffer depth, so a returning word always has a free slot.
   assign rd_issue = (state == READ) && (rd_cnt != RD_END) &&
                     (int'(fifo_count) + $countones(pipe_vld) < BUF_DEPTH);

   assign push      = pipe_vld[SRAM_RD_LAT-1];
   assign out_valid = (fifo_count != '0);
   assign out_data  = fifo_dout[DW-1:0];
   assign out_last  = out_valid && fifo_dout[DW];
   assign pop       = out_valid && out_ready;

   // NOTE: every output of this block gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      in_ready = (state == LOAD);
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = (WR_WORDS == 0) ? READ : LOAD;
         LOAD: if (beat && (wr_cnt == WR_LAST)) state_nx = READ;
         READ: if (pop && out_last) state_nx = FIN;
         FIN: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         pipe_vld  <= '0;
         pipe_last <= '0;
         sram_nWE  <= 1'b1;
         sram_adr  <= '0;
         sram_d_in <= '0;
      end else begin
         state     <= state_nx;
         pipe_vld  <= {pipe_vld[SRAM_RD_LAT-2:0], rd_issue};
         pipe_last <= {pipe_last[SRAM_RD_LAT-2:0], rd_issue && (rd_cnt == RD_LAST)};
         // Write strobe lasts exactly the one cycle after an accepted beat.
         sram_nWE  <= !beat;
         if ((state == IDLE) && start) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
         end
         if (beat) begin
            sram_adr  <= wr_cnt[AW-1:0];
            sram_d_in <= in_data;
            wr_cnt    <= wr_cnt + 1'b1;
         end
         if (rd_issue) begin
            sram_adr <= rd_cnt[AW-1:0];
            rd_cnt   <= rd_cnt + 1'b1;
         end
      end
   end

   sram_rd_fifo #(
      .W     (DW + 1),
      .DEPTH (BUF_DEPTH)
   ) u_rd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({pipe_last[SRAM_RD_LAT-1], sram_d_out}),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

endmodule
